// File: rtl/pipelined_sub_restore.sv
// Three-stage split-carry adder that rebuilds n1 = diff + n2.
// Ports: clk/rst_n, in_valid/in_ready/diff/n2, out_valid/out_ready/sum/range_err.
module pipelined_sub_restore #(
  parameter int W     = 12,
  parameter int SPLIT = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   diff,
  input  logic [W-1:0] n2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum,
  output logic         range_err
);

  localparam int HW = W + 1 - SPLIT;

  if (SPLIT < 1 || SPLIT > W) begin : g_bad_split
    $error("SPLIT must be in 1..W");
  end

  logic              adv;

  logic              s1_valid_q, s1_valid_d;
  logic [W:0]        s1_diff_q, s1_diff_d;
  logic [W:0]        s1_n2x_q, s1_n2x_d;

  logic              s2_valid_q, s2_valid_d;
  logic [SPLIT:0]    s2_lo_q, s2_lo_d;
  logic [HW-1:0]     s2_dhi_q, s2_dhi_d;
  logic [HW-1:0]     s2_nhi_q, s2_nhi_d;

  logic              out_valid_q, out_valid_d;
  logic [W:0]        sum_q, sum_d;
  logic              range_err_q, range_err_d;

  logic [HW-1:0]     hi_sum;

  // One stall signal for every stage: the pipeline only moves when
  // the output register is empty or being drained.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // The registered low-half carry enters here and nowhere else.
  assign hi_sum = s2_dhi_q + s2_nhi_q + HW'(s2_lo_q[SPLIT]);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_diff_d   = s1_diff_q;
    s1_n2x_d    = s1_n2x_q;
    s2_valid_d  = s2_valid_q;
    s2_lo_d     = s2_lo_q;
    s2_dhi_d    = s2_dhi_q;
    s2_nhi_d    = s2_nhi_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    range_err_d = range_err_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_diff_d   = diff;
      s1_n2x_d    = {n2[W-1], n2};
      s2_valid_d  = s1_valid_q;
      s2_lo_d     = {1'b0, s1_diff_q[SPLIT-1:0]}
                  + {1'b0, s1_n2x_q[SPLIT-1:0]};
      s2_dhi_d    = s1_diff_q[W:SPLIT];
      s2_nhi_d    = s1_n2x_q[W:SPLIT];
      out_valid_d = s2_valid_q;
      sum_d       = {hi_sum, s2_lo_q[SPLIT-1:0]};
      range_err_d = sum_d[W] ^ sum_d[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_n2x_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_lo_q     <= '0;
      s2_dhi_q    <= '0;
      s2_nhi_q    <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      range_err_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_diff_q   <= s1_diff_d;
      s1_n2x_q    <= s1_n2x_d;
      s2_valid_q  <= s2_valid_d;
      s2_lo_q     <= s2_lo_d;
      s2_dhi_q    <= s2_dhi_d;
      s2_nhi_q    <= s2_nhi_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      range_err_q <= range_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_pipelined_sub_restore.sv
// Directed and random-round-trip bench for pipelined_sub_restore.
// Drives at posedge+1, decides acceptance at negedge.
module tb_pipelined_sub_restore;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] diff = '0;
  logic [11:0] n2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [12:0] sum;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  logic [13:0] got_q[$];

  pipelined_sub_restore #(.W(12), .SPLIT(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .n2        (n2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && out_valid && out_ready)
      got_q.push_back({range_err, sum});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    diff = 13'd5; n2 = 12'd1;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (sum !== 13'h0) begin
      errors++; $display("FAIL rst_sum got %h want 0000", sum);
    end
    checks++;
    if (range_err !== 1'b0) begin
      errors++; $display("FAIL rst_range_err got %b want 0", range_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready);
    end
    got_q.delete();
    in_valid = 1'b1; diff = 13'd7; n2 = 12'd3;
    tick();
    diff = 13'd9;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL rst_flush got seen=%b n=%0d want 0/0", seen, got_q.size());
    end
  endtask

  task automatic test_basic();
    got_q.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    diff = 13'd150; n2 = 12'hFCE;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_lat1 got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_lat2 got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 13'h0064 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum got v=%b s=%h e=%b want 1/0064/0",
               out_valid, sum, range_err);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle got %b want 0", out_valid);
    end
  endtask

  task automatic run_pair(input logic [12:0] d0, input logic [11:0] m0,
                          input logic [12:0] d1, input logic [11:0] m1);
    got_q.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    diff = d0; n2 = m0;
    tick();
    diff = d1; n2 = m1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && got_q.size() < 2; c++) tick();
  endtask

  task automatic test_carry();
    logic [13:0] g;
    run_pair(13'd63, 12'd1, 13'h1FFF, 12'd1);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL carry_count got %0d want 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      checks++;
      if (g !== {1'b0, 13'h0040}) begin
        errors++; $display("FAIL carry_63p1 got %h want 0040", g);
      end
      g = got_q.pop_front();
      checks++;
      if (g !== {1'b0, 13'h0000}) begin
        errors++; $display("FAIL carry_m1p1 got %h want 0000", g);
      end
    end
  endtask

  task automatic test_range();
    logic [13:0] g;
    run_pair(13'h1000, 12'h7FF, 13'd4095, 12'd1);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL range_count got %0d want 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      checks++;
      if (g !== {1'b1, 13'h17FF}) begin
        errors++; $display("FAIL range_neg got %h want 37ff", g);
      end
      g = got_q.pop_front();
      checks++;
      if (g !== {1'b1, 13'h1000}) begin
        errors++; $display("FAIL range_pos got %h want 3000", g);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] bd[5];
    logic [11:0] bn[5];
    logic [13:0] be[5];
    logic [13:0] g;
    logic [12:0] prev;
    logic        held;
    int          acc;
    bd[0] = 13'd10;   bn[0] = 12'd5;    be[0] = {1'b0, 13'd15};
    bd[1] = 13'd100;  bn[1] = 12'hFFF;  be[1] = {1'b0, 13'd99};
    bd[2] = 13'h1F00; bn[2] = 12'd32;   be[2] = {1'b0, 13'h1F20};
    bd[3] = 13'd2000; bn[3] = 12'd2000; be[3] = {1'b1, 13'd4000};
    bd[4] = 13'd777;  bn[4] = 12'd0;    be[4] = {1'b0, 13'd777};
    got_q.delete();
    acc = 0; held = 1'b0; prev = '0;
    for (int c = 0; c < 40 && got_q.size() < 5; c++) begin
      out_ready = !(c >= 1 && c <= 4);
      in_valid = (acc < 5);
      if (acc < 5) begin
        diff = bd[acc]; n2 = bn[acc];
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
        if (held) begin
          checks++;
          if (sum !== prev) begin
            errors++; $display("FAIL bp_hold got %h want %h", sum, prev);
          end
        end
        prev = sum; held = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got_q.size() != 5) begin
      errors++; $display("FAIL bp_count got %0d want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        g = got_q.pop_front();
        checks++;
        if (g !== be[i]) begin
          errors++; $display("FAIL bp_item%0d got %h want %h", i, g, be[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] g;
    int first_c, last_c, nv;
    got_q.delete();
    first_c = -1; last_c = -1; nv = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      diff = 13'(c * 3); n2 = 12'(c);
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready c%0d got %b want 1", c, in_ready);
        end
      end
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c; nv++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (nv != 8 || last_c - first_c != 7) begin
      errors++;
      $display("FAIL b2b_throughput got n=%0d span=%0d want 8/7", nv, last_c - first_c);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL b2b_item%0d got none want %h", i, 13'(i * 4));
      end else begin
        g = got_q.pop_front();
        if (g !== {1'b0, 13'(i * 4)}) begin
          errors++; $display("FAIL b2b_item%0d got %h want %h", i, g, 13'(i * 4));
        end
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [12:0] exp_q[$];
    logic [11:0] n1, m2;
    logic [12:0] n1x, d;
    logic [13:0] g;
    logic [12:0] e;
    logic        acc;
    int sent, rcv;
    got_q.delete();
    sent = 0; rcv = 0;
    n1 = 12'($urandom); m2 = 12'($urandom);
    for (int c = 0; c < 60000 && rcv < N; c++) begin
      n1x = {n1[11], n1};
      d = n1x - {m2[11], m2};
      in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      diff = d; n2 = m2;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(n1x);
        sent++;
      end
      tick();
      if (acc) begin
        n1 = 12'($urandom); m2 = 12'($urandom);
      end
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        rcv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra got %h want none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== {1'b0, e}) begin
            errors++; $display("FAIL rnd_item%0d got %h want %h", rcv, g, {1'b0, e});
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rcv != N) begin
      errors++; $display("FAIL rnd_count got %0d want %0d", rcv, N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
